load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; the data bus is 32 bits and the address bus is 32 bits (byte address).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous and active-low.
REQ-004 req_i  in  1  core request valid.
REQ-005 ready_o  out  1  block idle; a request is accepted only when req_i and ready_o are both high.
REQ-006 we_i  in  1  1 = store, 0 = load.
REQ-007 size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 unsigned_i  in  1  loads only: 1 zero-extends, 0 sign-extends.
REQ-009 addr_i  in  32  byte address.
REQ-010 wdata_i  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 rdata_o  out  32  load result, valid when done_o is high, held until the next load completes.
REQ-012 done_o  out  1  one-cycle completion pulse.
REQ-013 err_o  out  1  qualifies done_o: misaligned or illegal access.
REQ-014 mem_rd_en_o  out  1  memory read strobe.
REQ-015 mem_wr_en_o  out  1  memory write strobe.
REQ-016 mem_addr_o  out  32  word-aligned memory address, {addr[31:2],2'b00}.
REQ-017 mem_data_o  out  32  memory write data.
REQ-018 mem_data_i  in  32  memory read data, valid combinationally while mem_rd_en_o is high and mem_ack_i is high.
REQ-019 mem_ack_i  in  1  memory ready; samples the access in the current cycle.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, STORE, RMW_RD, RMW_WR and DONE.
REQ-021 ready_o SHALL be high only in IDLE.
REQ-022 Request inputs SHALL be captured into registers on acceptance; the inputs are don't-care afterwards.
REQ-023 Transitions on acceptance in IDLE (cycle N):
- Illegal size, halfword with addr[0]=1, or word with addr[1:0]!=0: go to DONE with err.
- Legal load: go to LOAD.
- Legal word store: go to STORE.
- Legal byte or halfword store: go to RMW_RD.
REQ-024 LOAD SHALL assert mem_rd_en_o. On mem_ack_i it SHALL register the extracted and extended lane into rdata_o and go to DONE.
REQ-025 STORE SHALL assert mem_wr_en_o with mem_data_o=wdata. On mem_ack_i it SHALL go to DONE.
REQ-026 RMW_RD SHALL assert mem_rd_en_o. On mem_ack_i it SHALL register the merged word and go to RMW_WR.
- Merged word: the read word with the addressed byte or halfword lane replaced by the store data.
REQ-027 RMW_WR SHALL assert mem_wr_en_o with the merged word. On mem_ack_i it SHALL go to DONE.
REQ-028 DONE SHALL assert done_o for exactly one cycle and return to IDLE. err_o is high in that cycle only for error cases.
REQ-029 While mem_ack_i is low, the state, strobes, mem_addr_o and mem_data_o SHALL hold stable.
REQ-030 mem_rd_en_o and mem_wr_en_o SHALL never be high in the same cycle, and both SHALL be low in IDLE and DONE.
REQ-031 Byte lane k=addr[1:0] SHALL map to bits [8k+7:8k]; halfword lane addr[1] SHALL map to bits [16*addr[1]+15:16*addr[1]].
REQ-032 Sign extension SHALL replicate the lane MSB; zero extension SHALL fill with 0. Word loads SHALL ignore unsigned_i.
REQ-033 Latency with ack held high:
- Done at N+2 for load and word store.
- Done at N+3 for sub-word store.
- Done at N+1 for error.
- Each low-ack cycle adds one cycle.
REQ-034 Error requests SHALL issue no memory strobe, and rdata_o SHALL remain unchanged.
REQ-035 A new request SHALL be acceptable in the cycle after done_o (back-to-back throughput: one access per 3 or 4 cycles).

Reset
REQ-036 While rst_n is low, and immediately on its assertion, the block SHALL have:
- state IDLE;
- ready_o=1;
- done_o=0, err_o=0;
- mem_rd_en_o=0, mem_wr_en_o=0;
- mem_addr_o=0, mem_data_o=0, rdata_o=0.
REQ-037 Reset mid-operation SHALL abandon the access with no further strobes, and no done_o SHALL be produced for it.

Verification
REQ-038 Memory word 0x10=0x8899AABB. lb 0x10 -> rdata 0xFFFFFFBB at N+2. lbu 0x13 -> 0x00000088. lh 0x12 -> 0xFFFF8899. lhu 0x10 -> 0x0000AABB.
REQ-039 sb 0x11 with wdata 0x00000055 -> read at N+1, write 0x889955BB at N+2, done at N+3. sh 0x12 with wdata 0x1234 -> word 0x1234AABB.
REQ-040 sw 0x12 and lh 0x11 -> done_o and err_o at N+1, zero memory strobes, rdata unchanged. size_i=11 -> same response.
REQ-041 lw 0x10 with mem_ack_i low for 3 cycles -> mem_rd_en_o and mem_addr_o=0x10 held stable, done at N+5 with 0x8899AABB.
REQ-042 rst_n low during RMW_WR of sb 0x11 -> both strobes drop the same cycle, no done_o, memory unchanged, ready_o=1.
REQ-043 Random mixed traffic against a memory model: check a rd/wr strobe overlap never occurs and the memory contents match a byte-addressed reference.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side strobe signals of the load/store unit.
// The LSU connects through the slave modport and its environment through the master modport.
interface load_store_unit_if;
   logic        req_i;
   logic        ready_o;
   logic        we_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        done_o;
   logic        err_o;
   logic        mem_rd_en_o;
   logic        mem_wr_en_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;
   logic        mem_ack_i;

   modport slave (
      input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_data_i, mem_ack_i,
      output ready_o, rdata_o, done_o, err_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
   );

   modport master (
      output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_data_i, mem_ack_i,
      input  ready_o, rdata_o, done_o, err_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word loads with sign or zero extension and
// sub-word stores through a read-modify-write of the containing memory word.
module load_store_unit (
   input  logic                    clk,
   input  logic                    rst_n,
   load_store_unit_if.slave        bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STORE,
      RMW_RD,
      RMW_WR,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] merged_q, merged_d;
   logic        err_q, err_d;

   logic        misaligned;
   logic [7:0]  byteLane;
   logic [15:0] halfLane;
   logic [31:0] loadValue;
   logic [31:0] mergeValue;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         merged_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         merged_q   <= merged_d;
         err_q      <= err_d;
      end
   end

   // Lane extraction and merge always work on the captured address, never the live inputs.
   always_comb begin
      byteLane   = bus.mem_data_i[{addr_q[1:0], 3'b000} +: 8];
      halfLane   = addr_q[1] ? bus.mem_data_i[31:16] : bus.mem_data_i[15:0];
      loadValue  = bus.mem_data_i;
      mergeValue = bus.mem_data_i;
      case (size_q)
         2'b00: begin
            loadValue = {{24{~unsigned_q & byteLane[7]}}, byteLane};
            mergeValue[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            loadValue = {{16{~unsigned_q & halfLane[15]}}, halfLane};
            mergeValue[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: begin
            loadValue = bus.mem_data_i;
         end
      endcase
   end

   always_comb begin
      misaligned = (bus.size_i == 2'b11) ||
                   ((bus.size_i == 2'b01) && bus.addr_i[0]) ||
                   ((bus.size_i == 2'b10) && (bus.addr_i[1:0] != 2'b00));
   end

   always_comb begin
      state_d         = state_q;
      we_d            = we_q;
      size_d          = size_q;
      unsigned_d      = unsigned_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      rdata_d         = rdata_q;
      merged_d        = merged_q;
      err_d           = err_q;
      bus.ready_o     = 1'b0;
      bus.done_o      = 1'b0;
      bus.err_o       = 1'b0;
      bus.mem_rd_en_o = 1'b0;
      bus.mem_wr_en_o = 1'b0;
      bus.mem_data_o  = '0;

      case (state_q)
         IDLE: begin
            bus.ready_o = 1'b1;
            if (bus.req_i) begin
               we_d       = bus.we_i;
               size_d     = bus.size_i;
               unsigned_d = bus.unsigned_i;
               addr_d     = bus.addr_i;
               wdata_d    = bus.wdata_i;
               err_d      = misaligned;
               if (misaligned) begin
                  state_d = DONE;
               end else if (!bus.we_i) begin
                  state_d = LOAD;
               end else if (bus.size_i == 2'b10) begin
                  state_d = STORE;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         LOAD: begin
            bus.mem_rd_en_o = 1'b1;
            if (bus.mem_ack_i) begin
               rdata_d = loadValue;
               state_d = DONE;
            end
         end
         STORE: begin
            bus.mem_wr_en_o = 1'b1;
            bus.mem_data_o  = wdata_q;
            if (bus.mem_ack_i) begin
               state_d = DONE;
            end
         end
         RMW_RD: begin
            bus.mem_rd_en_o = 1'b1;
            if (bus.mem_ack_i) begin
               merged_d = mergeValue;
               state_d  = RMW_WR;
            end
         end
         RMW_WR: begin
            bus.mem_wr_en_o = 1'b1;
            bus.mem_data_o  = merged_q;
            if (bus.mem_ack_i) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.done_o = 1'b1;
            bus.err_o  = err_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.mem_addr_o = {addr_q[31:2], 2'b00};
   assign bus.rdata_o    = rdata_q;

endmodule
